// File: rtl/wb_pipe_reg.sv
// Write-back stage register: 2-entry skid buffer carrying {rdE, rdIdx, rdData}
// with a valid/ready handshake, synchronous flush and optional x0-write suppression.
module wb_pipe_reg #(
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 5,
    parameter bit X0_SUPPRESS = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rdE_in,
    input  logic [IDX_W-1:0]  rdIdx_in,
    input  logic [DATA_W-1:0] rdData_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rdE_out,
    output logic [IDX_W-1:0]  rdIdx_out,
    output logic [DATA_W-1:0] rdData_out,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        occ_q, occ_n;
    logic              in_ready_q, in_ready_n;
    logic              main_e_q, main_e_n, skid_e_q, skid_e_n;
    logic [IDX_W-1:0]  main_idx_q, main_idx_n, skid_idx_q, skid_idx_n;
    logic [DATA_W-1:0] main_data_q, main_data_n, skid_data_q, skid_data_n;
    logic              in_fire, out_fire, cap_e;

    function automatic logic capture_we(input logic we, input logic [IDX_W-1:0] idx);
        logic keep;
        keep = (X0_SUPPRESS == 1'b1) ? (idx != '0) : 1'b1;
        return we & keep;
    endfunction

    assign out_valid = (occ_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign cap_e     = capture_we(rdE_in, rdIdx_in);

    always_comb begin
        occ_n       = occ_q;
        main_e_n    = main_e_q;
        main_idx_n  = main_idx_q;
        main_data_n = main_data_q;
        skid_e_n    = skid_e_q;
        skid_idx_n  = skid_idx_q;
        skid_data_n = skid_data_q;
        if (flush_in) begin
            // Flush wins over any capture; a concurrent out_fire needs no action here.
            occ_n       = EMPTY;
            main_e_n    = 1'b0;
            main_idx_n  = '0;
            main_data_n = '0;
            skid_e_n    = 1'b0;
            skid_idx_n  = '0;
            skid_data_n = '0;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (in_fire) begin
                        occ_n       = ONE;
                        main_e_n    = cap_e;
                        main_idx_n  = rdIdx_in;
                        main_data_n = rdData_in;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_e_n    = cap_e;
                        main_idx_n  = rdIdx_in;
                        main_data_n = rdData_in;
                    end else if (in_fire) begin
                        occ_n       = FULL;
                        skid_e_n    = cap_e;
                        skid_idx_n  = rdIdx_in;
                        skid_data_n = rdData_in;
                    end else if (out_fire) begin
                        occ_n = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        occ_n       = ONE;
                        main_e_n    = skid_e_q;
                        main_idx_n  = skid_idx_q;
                        main_data_n = skid_data_q;
                        skid_e_n    = 1'b0;
                        skid_idx_n  = '0;
                        skid_data_n = '0;
                    end
                end
                default: occ_n = EMPTY;
            endcase
        end
        // Registered ready mirrors "skid empty" in the next state, keeping out_ready off this path.
        in_ready_n = (occ_n != FULL);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            occ_q       <= EMPTY;
            in_ready_q  <= 1'b1;
            main_e_q    <= 1'b0;
            main_idx_q  <= '0;
            main_data_q <= '0;
            skid_e_q    <= 1'b0;
            skid_idx_q  <= '0;
            skid_data_q <= '0;
        end else begin
            occ_q       <= occ_n;
            in_ready_q  <= in_ready_n;
            main_e_q    <= main_e_n;
            main_idx_q  <= main_idx_n;
            main_data_q <= main_data_n;
            skid_e_q    <= skid_e_n;
            skid_idx_q  <= skid_idx_n;
            skid_data_q <= skid_data_n;
        end
    end

    assign rdE_out    = main_e_q & out_valid;
    assign rdIdx_out  = main_idx_q;
    assign rdData_out = main_data_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: two instances (x0 suppression on/off) share stimulus.
module tb_wb_pipe_reg;

    logic        clk_in = 1'b0;
    logic        rst_in, flush_in, in_valid, out_ready, rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;

    logic        in_ready, out_valid, rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;
    logic [1:0]  occupancy;

    logic        in_ready0, out_valid0, rdE_out0;
    logic [4:0]  rdIdx_out0;
    logic [31:0] rdData_out0;
    logic [1:0]  occupancy0;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    wb_pipe_reg #(.DATA_W(32), .IDX_W(5), .X0_SUPPRESS(1'b1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rdData_in(rdData_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdE_out(rdE_out), .rdIdx_out(rdIdx_out), .rdData_out(rdData_out),
        .occupancy(occupancy)
    );

    wb_pipe_reg #(.DATA_W(32), .IDX_W(5), .X0_SUPPRESS(1'b0)) u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready0),
        .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rdData_in(rdData_in),
        .out_valid(out_valid0), .out_ready(out_ready),
        .rdE_out(rdE_out0), .rdIdx_out(rdIdx_out0), .rdData_out(rdData_out0),
        .occupancy(occupancy0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic v, input logic e, input logic [4:0] idx, input logic [31:0] d);
        in_valid  = v;
        rdE_in    = e;
        rdIdx_in  = idx;
        rdData_in = d;
    endtask

    initial begin
        rst_in = 1'b1; flush_in = 1'b0; out_ready = 1'b0;
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rdE", rdE_out, 0);
        chk("rst_idx", rdIdx_out, 0);
        chk("rst_data", rdData_out, 0);
        chk("rst_occ", occupancy, 0);
        tick();
        rst_in = 1'b0;

        // 1: single transfer
        out_ready = 1'b1;
        offer(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t1_valid", out_valid, 1);
        chk("t1_rdE", rdE_out, 1);
        chk("t1_idx", rdIdx_out, 5);
        chk("t1_data", rdData_out, 32'hDEADBEEF);
        chk("t1_occ", occupancy, 1);
        tick();
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_rdE_drop", rdE_out, 0);
        chk("t1_idx_hold", rdIdx_out, 5);
        chk("t1_occ_empty", occupancy, 0);

        // 2: streaming
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, 1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
            chk("t2_valid", out_valid, 1);
            chk("t2_idx", rdIdx_out, i);
            chk("t2_data", rdData_out, 32'h100 + i);
            chk("t2_occ", occupancy, 1);
            chk("t2_in_ready", in_ready, 1);
        end
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("t2_drain", occupancy, 0);

        // 3: back-pressure A, B, C
        out_ready = 1'b0;
        offer(1'b1, 1'b1, 5'd10, 32'hA);
        tick();
        chk("t3_occA", occupancy, 1);
        chk("t3_rdyA", in_ready, 1);
        offer(1'b1, 1'b1, 5'd11, 32'hB);
        tick();
        chk("t3_occB", occupancy, 2);
        chk("t3_rdyB", in_ready, 0);
        chk("t3_headA", rdIdx_out, 10);
        offer(1'b1, 1'b1, 5'd12, 32'hC);
        tick();
        chk("t3_stall_occ", occupancy, 2);
        chk("t3_stall_idx", rdIdx_out, 10);
        chk("t3_stall_data", rdData_out, 32'hA);
        chk("t3_stall_rdy", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("t3_outB_idx", rdIdx_out, 11);
        chk("t3_outB_data", rdData_out, 32'hB);
        chk("t3_outB_occ", occupancy, 1);
        chk("t3_outB_rdy", in_ready, 1);
        tick();
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t3_outC_idx", rdIdx_out, 12);
        chk("t3_outC_data", rdData_out, 32'hC);
        chk("t3_outC_valid", out_valid, 1);
        tick();
        chk("t3_end_valid", out_valid, 0);
        chk("t3_end_occ", occupancy, 0);

        // 4: x0 suppression
        offer(1'b1, 1'b1, 5'd0, 32'h1234);
        tick();
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t4_valid", out_valid, 1);
        chk("t4_rdE_sup", rdE_out, 0);
        chk("t4_data", rdData_out, 32'h1234);
        chk("t4_rdE_nosup", rdE_out0, 1);
        chk("t4_data_nosup", rdData_out0, 32'h1234);
        tick();

        // 5: flush in FULL with concurrent in_valid
        out_ready = 1'b0;
        offer(1'b1, 1'b1, 5'd20, 32'h20);
        tick();
        offer(1'b1, 1'b1, 5'd21, 32'h21);
        tick();
        chk("t5_full", occupancy, 2);
        offer(1'b1, 1'b1, 5'd22, 32'h22);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t5_occ", occupancy, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_rdy", in_ready, 1);
        chk("t5_idx", rdIdx_out, 0);
        chk("t5_data", rdData_out, 0);
        out_ready = 1'b1;
        tick();
        chk("t5_no_ghost", out_valid, 0);
        // flush wins over a real in_fire from ONE
        offer(1'b1, 1'b1, 5'd23, 32'h23);
        tick();
        chk("t5_one", occupancy, 1);
        out_ready = 1'b0;
        offer(1'b1, 1'b1, 5'd24, 32'h24);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t5_drop_occ", occupancy, 0);
        chk("t5_drop_valid", out_valid, 0);

        // 6: async reset while FULL
        offer(1'b1, 1'b1, 5'd25, 32'h25);
        tick();
        offer(1'b1, 1'b1, 5'd26, 32'h26);
        tick();
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t6_full", occupancy, 2);
        #2 rst_in = 1'b1;
        #1;
        chk("t6_occ", occupancy, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_rdy", in_ready, 1);
        chk("t6_idx", rdIdx_out, 0);
        chk("t6_data", rdData_out, 0);
        #1 rst_in = 1'b0;
        out_ready = 1'b1;
        offer(1'b1, 1'b1, 5'd27, 32'hCAFE);
        tick();
        offer(1'b0, 1'b0, 5'd0, 32'h0);
        chk("t6_new_valid", out_valid, 1);
        chk("t6_new_idx", rdIdx_out, 27);
        chk("t6_new_data", rdData_out, 32'hCAFE);
        chk("t6_new_rdE", rdE_out, 1);
        tick();
        chk("t6_after", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
